// File: rtl/tri_side_sqrt.sv
// tri_side_sqrt: exact floor square roots of three squared side lengths, one result bit per cycle.
module tri_side_sqrt #(
  parameter int IN_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   xx,
  input  logic [IN_W-1:0]   yy,
  input  logic [IN_W-1:0]   zz,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IN_W/2-1:0] ss,
  output logic [IN_W/2-1:0] dd,
  output logic [IN_W/2-1:0] ff,
  output logic              s_ovf
);
  localparam int H  = IN_W / 2;
  localparam int RW = H + 2;
  localparam int CW = $clog2(H) > 0 ? $clog2(H) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [IN_W-1:0] rad, op_y, op_z;
  logic [RW-1:0] rem, rem_nx;
  logic [RW+1:0] rem_sh, trial;
  logic [H-1:0] root, root_nx;
  logic [CW-1:0] cnt;
  logic [1:0] idx;
  logic fit, last;
  function automatic logic ovf(input logic [H-1:0] v);
    return 32'(v) > 32'd127;
  endfunction
  // restoring digit step: bring down two radicand bits, try subtracting 4*root+1
  assign rem_sh  = {rem, rad[IN_W-1 -: 2]};
  assign trial   = {2'b00, root, 2'b01};
  assign fit     = rem_sh >= trial;
  assign rem_nx  = RW'(fit ? rem_sh - trial : rem_sh);
  assign root_nx = {root[H-2:0], fit};
  assign last    = cnt == '0;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE && in_valid) state_nx = CALC;
    if (state == CALC && last && idx == 2'd2) state_nx = DONE;
    if (state == DONE && out_ready) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rad   <= '0;
      op_y  <= '0;
      op_z  <= '0;
      rem   <= '0;
      root  <= '0;
      cnt   <= '0;
      idx   <= '0;
      ss    <= '0;
      dd    <= '0;
      ff    <= '0;
      s_ovf <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      rad  <= xx;
      op_y <= yy;
      op_z <= zz;
      rem  <= '0;
      root <= '0;
      cnt  <= CW'(H - 1);
      idx  <= '0;
    end else if (state == CALC && last) begin
      // operand finished: publish its root and start the next one without a gap
      rad  <= idx == 2'd0 ? op_y : op_z;
      rem  <= '0;
      root <= '0;
      cnt  <= CW'(H - 1);
      idx  <= idx + 2'd1;
      ss   <= idx == 2'd0 ? root_nx : ss;
      dd   <= idx == 2'd1 ? root_nx : dd;
      ff   <= idx == 2'd2 ? root_nx : ff;
      s_ovf <= idx == 2'd2 ? (ovf(ss) | ovf(dd) | ovf(root_nx)) : s_ovf;
    end else if (state == CALC) begin
      rad  <= {rad[IN_W-3:0], 2'b00};
      rem  <= rem_nx;
      root <= root_nx;
      cnt  <= cnt - CW'(1);
    end
endmodule

// File: tb/tb_tri_side_sqrt.sv
// tb_tri_side_sqrt: scoreboard bench for tri_side_sqrt against an integer floor-sqrt model.
module tb_tri_side_sqrt;
  logic clk = 0, rst_n = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, s_ovf;
  logic [15:0] xx = 0, yy = 0, zz = 0;
  logic [7:0] ss, dd, ff;
  typedef struct {int s; int d; int f; int o; int acc;} exp_t;
  exp_t sb[$];
  exp_t cur;
  int total = 0, bad = 0, cyc = 0, ready_mode = 0, last_acc = -1;
  bit seen = 0, hold_mode = 0;

  always #5 clk = ~clk;

  tri_side_sqrt #(.IN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .xx(xx), .yy(yy), .zz(zz), .out_valid(out_valid), .out_ready(out_ready),
    .ss(ss), .dd(dd), .ff(ff), .s_ovf(s_ovf)
  );

  function automatic int isqrt(int v);
    int r = int'($floor($sqrt(real'(v))));
    while (r * r > v) r--;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic exp_t model(int x, int y, int z, int acc);
    exp_t e;
    e.s = isqrt(x);
    e.d = isqrt(y);
    e.f = isqrt(z);
    e.o = (e.s > 127 || e.d > 127 || e.f > 127) ? 1 : 0;
    e.acc = acc;
    return e;
  endfunction

  function automatic int rnd_op();
    int k;
    case ($urandom % 4)
      0: return int'($urandom % 65536);
      1: return int'($urandom % 300);
      2: return 65535 - int'($urandom % 300);
      default: begin
        k = int'($urandom % 256);
        k = k * k - int'($urandom % 2);
        return k < 0 ? 0 : k;
      end
    endcase
  endfunction

  task automatic chk(string n, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = ready_mode == 0 ? 1'b1 : ready_mode == 2 ? 1'b0 : ($urandom % 3 != 0);
  end

  // monitor: compares on output presentation, pushes expectations on accepts
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      sb.delete();
      seen = 0;
    end else begin
      chk("in_ready", int'(in_ready), int'(sb.size() == 0 && !seen));
      if (out_valid) begin
        if (!seen) begin
          if (sb.size() == 0) chk("spurious_out_valid", 1, 0);
          else begin
            cur = sb.pop_front();
            seen = 1;
            chk("latency", cyc - cur.acc, 24);
            chk("ss", int'(ss), cur.s);
            chk("dd", int'(dd), cur.d);
            chk("ff", int'(ff), cur.f);
            chk("s_ovf", int'(s_ovf), cur.o);
          end
        end else begin
          chk("ss_hold", int'(ss), cur.s);
          chk("dd_hold", int'(dd), cur.d);
          chk("ff_hold", int'(ff), cur.f);
          chk("s_ovf_hold", int'(s_ovf), cur.o);
        end
        if (out_ready) seen = 0;
      end else if (seen) begin
        chk("out_valid_held", 0, 1);
        seen = 0;
      end
      if (in_valid && in_ready) begin
        if (hold_mode && last_acc >= 0) chk("accept_spacing", cyc + 1 - last_acc, 26);
        last_acc = cyc + 1;
        sb.push_back(model(int'(xx), int'(yy), int'(zz), cyc + 1));
      end
    end
  end

  task automatic send(int x, int y, int z);
    int n = 0;
    while (!in_ready && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) chk("send_timeout", 0, 1);
    in_valid = 1;
    xx = 16'(x);
    yy = 16'(y);
    zz = 16'(z);
    @(posedge clk);
    #1;
    in_valid = 0;
    xx = 16'($urandom);
    yy = 16'($urandom);
    zz = 16'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || seen) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) chk("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1 rst_n = 0;
    #1;
    chk("rst_ss", int'(ss), 0);
    chk("rst_dd", int'(dd), 0);
    chk("rst_ff", int'(ff), 0);
    chk("rst_s_ovf", int'(s_ovf), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", int'(in_ready), 1);
    send(100, 144, 169); drain();
    send(0, 1, 2); drain();
    send(15, 16, 17); drain();
    send(16383, 16384, 65535); drain();
    ready_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send(50000, 3, 99);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_out_valid_rise", int'(out_valid), 1);
    repeat (5) @(posedge clk);
    #1;
    chk("bp_out_valid_stable", int'(out_valid), 1);
    chk("bp_in_ready_low", int'(in_ready), 0);
    chk("bp_ss", int'(ss), 223);
    ready_mode = 0;
    drain();
    send(1000, 2000, 3000);
    repeat (9) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("abort_ss", int'(ss), 0);
    chk("abort_dd", int'(dd), 0);
    chk("abort_ff", int'(ff), 0);
    chk("abort_s_ovf", int'(s_ovf), 0);
    chk("abort_out_valid", int'(out_valid), 0);
    sb.delete();
    seen = 0;
    @(posedge clk);
    #1 rst_n = 1;
    send(4, 9, 25); drain();
    last_acc = -1;
    hold_mode = 1;
    for (int i = 0; i < 130; i++) begin
      in_valid = 1;
      xx = 16'($urandom);
      yy = 16'($urandom);
      zz = 16'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    hold_mode = 0;
    drain();
    ready_mode = 1;
    for (int i = 0; i < 2000; i++) begin
      send(rnd_op(), rnd_op(), rnd_op());
      if ($urandom % 8 == 0) repeat ($urandom % 4) @(posedge clk);
      #0;
    end
    drain();
    ready_mode = 0;
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
